// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: CA width, CA field layout, address assembly and the CA receiver states.
package hyperbus_pkg;

    localparam int unsigned CA_W = 48;

    typedef struct packed {
        logic        rw;
        logic        addr_space;
        logic        burst_type;
        logic [28:0] addr_hi;
        logic [12:0] rsvd;
        logic [2:0]  addr_lo;
    } ca_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_CS
    } cmd_addr_rx_state_e;

    function automatic logic [31:0] ca_to_addr(input ca_t ca);
        return {ca.addr_hi, ca.addr_lo};
    endfunction

endpackage

// File: rtl/cmd_addr_rx_if.sv
// Beat input and decoded-CA output bundle of the HyperBus CA receiver.
interface cmd_addr_rx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              cs_n_i;
    logic              beat_valid_i;
    logic [DATA_W-1:0] beat_i;
    logic              ca_valid_o;
    logic              ca_ready_i;
    logic              rw_o;
    logic              address_space_o;
    logic              burst_type_o;
    logic [31:0]       address_o;
    logic              abort_o;
    logic              overrun_o;
    logic              reserved_err_o;

    modport master (
        output cs_n_i, beat_valid_i, beat_i, ca_ready_i,
        input  ca_valid_o, rw_o, address_space_o, burst_type_o, address_o,
               abort_o, overrun_o, reserved_err_o
    );

    modport slave (
        input  cs_n_i, beat_valid_i, beat_i, ca_ready_i,
        output ca_valid_o, rw_o, address_space_o, burst_type_o, address_o,
               abort_o, overrun_o, reserved_err_o
    );
endinterface

// File: rtl/cmd_addr_rx.sv
// HyperBus Command-Address receiver: collects MSB-first CA beats while CS# is low and decodes them.
// Optional reserved-bit check is enabled by defining CMD_ADDR_RX_RSVD_CHECK_EN.
module cmd_addr_rx
    import hyperbus_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    cmd_addr_rx_if.slave  bus
);

    localparam int unsigned     NB     = CA_W / DATA_W;
    localparam int unsigned     CNT_W  = 3;
    localparam int unsigned     SREG_W = CA_W - DATA_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NB - 1);

    if (!(DATA_W == 8 || DATA_W == 16)) begin : g_bad_data_w
        $error("cmd_addr_rx: DATA_W must be 8 or 16");
    end

    cmd_addr_rx_state_e state;
    logic [CNT_W-1:0]   cnt;
    logic [SREG_W-1:0]  sreg;

    logic               ca_valid;
    logic               rw;
    logic               addr_space;
    logic               burst_type;
    logic [31:0]        address;
    logic               abort;
    logic               overrun;

    logic               handshake;
    logic               last_beat;
    ca_t                ca_next;

    // Shift register only holds the beats before the last; the last beat is taken straight from the bus.
    assign ca_next   = ca_t'({sreg, bus.beat_i});
    assign handshake = ca_valid && bus.ca_ready_i;
    assign last_beat = (state == COLLECT) && !bus.cs_n_i && bus.beat_valid_i && (cnt == LAST);

`ifdef CMD_ADDR_RX_RSVD_CHECK_EN
    logic rsvd_err;
`else
    logic unused_rsvd;
    assign unused_rsvd = ^ca_next.rsvd;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            ca_valid   <= 1'b0;
            rw         <= 1'b0;
            addr_space <= 1'b0;
            burst_type <= 1'b0;
            address    <= '0;
            abort      <= 1'b0;
            overrun    <= 1'b0;
`ifdef CMD_ADDR_RX_RSVD_CHECK_EN
            rsvd_err   <= 1'b0;
`endif
        end else begin
            abort   <= 1'b0;
            overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.cs_n_i && bus.beat_valid_i) begin
                        sreg  <= {sreg[SREG_W-DATA_W-1:0], bus.beat_i};
                        cnt   <= CNT_W'(1);
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    // CS# closing wins over a beat presented in the same cycle.
                    if (bus.cs_n_i) begin
                        abort <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (bus.beat_valid_i) begin
                        sreg <= {sreg[SREG_W-DATA_W-1:0], bus.beat_i};
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= WAIT_CS;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WAIT_CS: begin
                    if (bus.cs_n_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // A completed CA loads only if the output slot is free or being emptied this cycle.
            if (last_beat) begin
                if (!ca_valid || handshake) begin
                    ca_valid   <= 1'b1;
                    rw         <= ca_next.rw;
                    addr_space <= ca_next.addr_space;
                    burst_type <= ca_next.burst_type;
                    address    <= ca_to_addr(ca_next);
`ifdef CMD_ADDR_RX_RSVD_CHECK_EN
                    rsvd_err   <= |ca_next.rsvd;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                ca_valid <= 1'b0;
`ifdef CMD_ADDR_RX_RSVD_CHECK_EN
                rsvd_err <= 1'b0;
`endif
            end
        end
    end

    assign bus.ca_valid_o      = ca_valid;
    assign bus.rw_o            = rw;
    assign bus.address_space_o = addr_space;
    assign bus.burst_type_o    = burst_type;
    assign bus.address_o       = address;
    assign bus.abort_o         = abort;
    assign bus.overrun_o       = overrun;
`ifdef CMD_ADDR_RX_RSVD_CHECK_EN
    assign bus.reserved_err_o  = rsvd_err;
`else
    assign bus.reserved_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_addr_rx.sv
// Scoreboard bench for cmd_addr_rx: 16-bit and 8-bit instances share clock and reset.
module tb_cmd_addr_rx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmd_addr_rx_if #(.DATA_W(16)) bus16 ();
    cmd_addr_rx_if #(.DATA_W(8))  bus8 ();

    cmd_addr_rx #(.DATA_W(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16.slave));
    cmd_addr_rx #(.DATA_W(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8.slave));

    typedef struct packed {
        logic        rw;
        logic        as;
        logic        bt;
        logic [31:0] addr;
        logic        rsvd;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t model(input logic [47:0] ca);
        exp_t e;
        e.rw   = ca[47];
        e.as   = ca[46];
        e.bt   = ca[45];
        e.addr = {ca[44:16], ca[2:0]};
`ifdef CMD_ADDR_RX_RSVD_CHECK_EN
        e.rsvd = |ca[15:3];
`else
        e.rsvd = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t obs16();
        return {bus16.rw_o, bus16.address_space_o, bus16.burst_type_o, bus16.address_o, bus16.reserved_err_o};
    endfunction

    function automatic exp_t obs8();
        return {bus8.rw_o, bus8.address_space_o, bus8.burst_type_o, bus8.address_o, bus8.reserved_err_o};
    endfunction

    function automatic logic [39:0] all16();
        return {bus16.ca_valid_o, bus16.rw_o, bus16.address_space_o, bus16.burst_type_o,
                bus16.address_o, bus16.abort_o, bus16.overrun_o, bus16.reserved_err_o};
    endfunction

    function automatic logic [39:0] all8();
        return {bus8.ca_valid_o, bus8.rw_o, bus8.address_space_o, bus8.burst_type_o,
                bus8.address_o, bus8.abort_o, bus8.overrun_o, bus8.reserved_err_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic cs_n, input logic bv, input logic [15:0] b);
        bus16.cs_n_i       = cs_n;
        bus16.beat_valid_i = bv;
        bus16.beat_i       = b;
    endtask

    task automatic drive8(input logic cs_n, input logic bv, input logic [7:0] b);
        bus8.cs_n_i       = cs_n;
        bus8.beat_valid_i = bv;
        bus8.beat_i       = b;
    endtask

    // Drives a full CA; returns right after the edge that captured the last beat.
    task automatic send16(input logic [47:0] ca, input int gap, input bit push, input bit rdy_last);
        if (push) q16.push_back(model(ca));
        for (int i = 0; i < 3; i++) begin
            if (i == 2 && rdy_last) bus16.ca_ready_i = 1'b1;
            drive16(1'b0, 1'b1, ca[47-16*i -: 16]);
            step();
            if (i < 2) begin
                drive16(1'b0, 1'b0, 16'h0);
                repeat (gap) step();
            end
        end
        drive16(1'b0, 1'b0, 16'h0);
    endtask

    task automatic send8(input logic [47:0] ca);
        q8.push_back(model(ca));
        for (int i = 0; i < 6; i++) begin
            drive8(1'b0, 1'b1, ca[47-8*i -: 8]);
            step();
        end
        drive8(1'b0, 1'b0, 8'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_checks++;
        if (all16() !== 40'h0) begin
            n_fail++;
            $display("FAIL reset16: outputs %h required 0", all16());
        end
        n_checks++;
        if (all8() !== 40'h0) begin
            n_fail++;
            $display("FAIL reset8: outputs %h required 0", all8());
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_linear();
        exp_t e;
        bus16.ca_ready_i = 1'b1;
        send16(48'hE246_8ACF_0000, 0, 1'b1, 1'b0);
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL read_valid: ca_valid %b required 1", bus16.ca_valid_o);
        end
        e = q16.pop_front();
        n_checks++;
        if (obs16() !== e || e.addr !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_fields: got %h required %h", obs16(), e);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_valid_clear: ca_valid %b required 0", bus16.ca_valid_o);
        end
    endtask

    task automatic test_write_gaps();
        exp_t e;
        send16(48'h0000_0000_0005, 2, 1'b1, 1'b0);
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_valid: ca_valid %b required 1", bus16.ca_valid_o);
        end
        e = q16.pop_front();
        n_checks++;
        if (obs16() !== e) begin
            n_fail++;
            $display("FAIL gap_fields: got %h required %h", obs16(), e);
        end
        step();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_single: ca_valid %b required 0", bus16.ca_valid_o);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
    endtask

    task automatic test_abort();
        exp_t e;
        drive16(1'b0, 1'b1, 16'h1111);
        step();
        drive16(1'b0, 1'b1, 16'h2222);
        step();
        // CS# rises together with the would-be last beat
        drive16(1'b1, 1'b1, 16'h3333);
        step();
        n_checks++;
        if ({bus16.abort_o, bus16.ca_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_pulse: abort,valid %b required 10", {bus16.abort_o, bus16.ca_valid_o});
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
        n_checks++;
        if (bus16.abort_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear: abort %b required 0", bus16.abort_o);
        end
        send16(48'h6000_1234_0003, 0, 1'b1, 1'b0);
        e = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== e) begin
            n_fail++;
            $display("FAIL abort_next: valid %b got %h required %h", bus16.ca_valid_o, obs16(), e);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bus16.ca_ready_i = 1'b0;
        send16(48'hE246_8ACF_0000, 0, 1'b1, 1'b0);
        e = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== e) begin
            n_fail++;
            $display("FAIL rstmid_pre: valid %b got %h required %h", bus16.ca_valid_o, obs16(), e);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
        drive16(1'b0, 1'b1, 16'hABCD);
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (all16() !== 40'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: outputs %h required 0", all16());
        end
        rst = 1'b0;
        drive16(1'b1, 1'b0, 16'h0);
        step();
        bus16.ca_ready_i = 1'b1;
        send16(48'h0000_0000_0005, 0, 1'b1, 1'b0);
        e = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== e) begin
            n_fail++;
            $display("FAIL rstmid_next: valid %b got %h required %h", bus16.ca_valid_o, obs16(), e);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
    endtask

    task automatic test_overrun();
        exp_t ea;
        exp_t eb;
        bus16.ca_ready_i = 1'b0;
        send16(48'h2000_0001_0001, 0, 1'b1, 1'b0);
        ea = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== ea) begin
            n_fail++;
            $display("FAIL ovr_a: valid %b got %h required %h", bus16.ca_valid_o, obs16(), ea);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
        send16(48'hC000_FFFF_0007, 0, 1'b0, 1'b0);
        n_checks++;
        if ({bus16.ca_valid_o, bus16.overrun_o} !== 2'b11 || obs16() !== ea) begin
            n_fail++;
            $display("FAIL ovr_pulse: valid,overrun %b got %h required 11 %h",
                     {bus16.ca_valid_o, bus16.overrun_o}, obs16(), ea);
        end
        step();
        n_checks++;
        if (bus16.overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: overrun %b required 0", bus16.overrun_o);
        end
        bus16.ca_ready_i = 1'b1;
        drive16(1'b1, 1'b0, 16'h0);
        step();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_accept: ca_valid %b required 0", bus16.ca_valid_o);
        end
        // Second CA completes in the handshake cycle of the first
        bus16.ca_ready_i = 1'b0;
        send16(48'h4000_00AB_0002, 0, 1'b1, 1'b0);
        ea = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== ea) begin
            n_fail++;
            $display("FAIL hs_a: valid %b got %h required %h", bus16.ca_valid_o, obs16(), ea);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
        send16(48'hA000_0F00_0006, 0, 1'b1, 1'b1);
        eb = q16.pop_front();
        n_checks++;
        if ({bus16.ca_valid_o, bus16.overrun_o} !== 2'b10 || obs16() !== eb) begin
            n_fail++;
            $display("FAIL hs_b: valid,overrun %b got %h required 10 %h",
                     {bus16.ca_valid_o, bus16.overrun_o}, obs16(), eb);
        end
        step();
        n_checks++;
        if ({bus16.ca_valid_o, bus16.overrun_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL hs_after: valid,overrun %b required 00", {bus16.ca_valid_o, bus16.overrun_o});
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
    endtask

    task automatic test_payload();
        exp_t e;
        int   vcnt;
        bus16.ca_ready_i = 1'b1;
        send16(48'hA555_5555_0002, 0, 1'b1, 1'b0);
        e = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== e) begin
            n_fail++;
            $display("FAIL pay_ca: valid %b got %h required %h", bus16.ca_valid_o, obs16(), e);
        end
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive16(1'b0, 1'b1, 16'($urandom));
            step();
            if (bus16.ca_valid_o === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt !== 0 || {bus16.rw_o, bus16.address_space_o, bus16.burst_type_o, bus16.address_o}
                          !== {e.rw, e.as, e.bt, e.addr}) begin
            n_fail++;
            $display("FAIL pay_hold: extra valids %0d addr %h required 0 %h", vcnt, bus16.address_o, e.addr);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
        send16(48'h8000_0003_0001, 0, 1'b1, 1'b0);
        e = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== e) begin
            n_fail++;
            $display("FAIL pay_next: valid %b got %h required %h", bus16.ca_valid_o, obs16(), e);
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
    endtask

    task automatic test_reserved();
        exp_t e;
        send16(48'h0000_0000_0008, 0, 1'b1, 1'b0);
        e = q16.pop_front();
        n_checks++;
        if (bus16.ca_valid_o !== 1'b1 || obs16() !== e || bus16.address_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rsvd_ca: valid %b got %h required %h", bus16.ca_valid_o, obs16(), e);
        end
        step();
        n_checks++;
        if ({bus16.ca_valid_o, bus16.reserved_err_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rsvd_clear: valid,rsvd %b required 00", {bus16.ca_valid_o, bus16.reserved_err_o});
        end
        drive16(1'b1, 1'b0, 16'h0);
        step();
    endtask

    task automatic test_width8();
        exp_t e;
        bus8.ca_ready_i = 1'b1;
        send8(48'hE246_8ACF_0000);
        e = q8.pop_front();
        n_checks++;
        if (bus8.ca_valid_o !== 1'b1 || obs8() !== e || e.addr !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL w8_ca: valid %b got %h required %h", bus8.ca_valid_o, obs8(), e);
        end
        drive8(1'b1, 1'b0, 8'h0);
        step();
        n_checks++;
        if (bus8.ca_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_clear: ca_valid %b required 0", bus8.ca_valid_o);
        end
        n_checks++;
        if (q16.size() !== 0 || q8.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: left %0d/%0d required 0/0", q16.size(), q8.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        drive16(1'b1, 1'b0, 16'h0);
        drive8(1'b1, 1'b0, 8'h0);
        bus16.ca_ready_i = 1'b0;
        bus8.ca_ready_i  = 1'b0;
        test_reset();
        test_read_linear();
        test_write_gaps();
        test_abort();
        test_reset_mid();
        test_overrun();
        test_payload();
        test_reserved();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
